// File: rtl/invader_formation_ctrl.sv
// Formation motion controller for the enemy grid: marches the formation
// sideways once every N frames, drops a row and reverses at the screen
// edges, and freezes with an invasion flag when it reaches the player zone.
module invader_formation_ctrl #(
    parameter int COLS       = 8,
    parameter int ROWS       = 3,
    parameter int X_START    = 32,
    parameter int X_SPACING  = 64,
    parameter int Y_START    = 40,
    parameter int Y_SPACING  = 50,
    parameter int SPRITE_W   = 32,
    parameter int SPRITE_H   = 16,
    parameter int X_MIN      = 0,
    parameter int X_MAX      = 640,
    parameter int STEP_X     = 8,
    parameter int STEP_Y     = 16,
    parameter int Y_LIMIT    = 400,
    parameter int MIN_PERIOD = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 vga_vs,
    input  logic                 enable,
    input  logic                 restart,
    input  logic [4:0]           alive_count,
    output logic [COLS*10-1:0]   col_x,
    output logic [ROWS*10-1:0]   row_y,
    output logic                 dir_right,
    output logic                 step_pulse,
    output logic                 invaded
);

    typedef enum logic [1:0] {IDLE, MARCH, DESCEND, INVADED} state_t;

    // Span of the formation measured from column 0's left edge.
    localparam int FORM_W    = (COLS - 1) * X_SPACING + SPRITE_W;
    localparam int DROP_SPAN = (ROWS - 1) * Y_SPACING + SPRITE_H;

    localparam logic [9:0]  X_START10  = 10'(X_START);
    localparam logic [9:0]  Y_START10  = 10'(Y_START);
    localparam logic [9:0]  STEP_X10   = 10'(STEP_X);
    localparam logic [9:0]  STEP_Y10   = 10'(STEP_Y);
    localparam logic [10:0] STEP_X11   = 11'(STEP_X);
    localparam logic [10:0] STEP_Y11   = 11'(STEP_Y);
    localparam logic [10:0] FORM_W11   = 11'(FORM_W);
    localparam logic [10:0] SPAN11     = 11'(DROP_SPAN);
    localparam logic [10:0] X_MIN11    = 11'(X_MIN);
    localparam logic [10:0] X_MAX11    = 11'(X_MAX);
    localparam logic [10:0] Y_LIMIT11  = 11'(Y_LIMIT);
    localparam logic [4:0]  MIN_PER5   = 5'(MIN_PERIOD);

    state_t      state, state_n;
    logic [9:0]  base_x, base_x_n;
    logic [9:0]  base_y, base_y_n;
    logic        dir_n, pulse_n, invaded_n;
    logic [4:0]  frame_cnt, frame_cnt_n;
    logic        vs_s1, vs_s2;
    logic        frame_edge;
    logic [4:0]  period;
    logic [5:0]  cnt_inc;
    logic        right_hit, left_hit, invade_hit;

    // Two-stage capture of the vertical sync; restart also re-arms it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
        end else if (restart) begin
            vs_s1 <= 1'b1;
            vs_s2 <= 1'b1;
        end else begin
            vs_s1 <= vga_vs;
            vs_s2 <= vs_s1;
        end
    end

    // Registered formation state, loaded from the next-state logic.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            base_x     <= X_START10;
            base_y     <= Y_START10;
            dir_right  <= 1'b1;
            step_pulse <= 1'b0;
            invaded    <= 1'b0;
            frame_cnt  <= 5'd0;
        end else begin
            state      <= state_n;
            base_x     <= base_x_n;
            base_y     <= base_y_n;
            dir_right  <= dir_n;
            step_pulse <= pulse_n;
            invaded    <= invaded_n;
            frame_cnt  <= frame_cnt_n;
        end
    end

    // Frame pacing, edge tests and the march/descend/invade state machine.
    always_comb begin
        state_n     = state;
        base_x_n    = base_x;
        base_y_n    = base_y;
        dir_n       = dir_right;
        pulse_n     = 1'b0;
        invaded_n   = invaded;
        frame_cnt_n = frame_cnt;

        frame_edge = vs_s2 & ~vs_s1;
        period     = (alive_count < MIN_PER5) ? MIN_PER5 : alive_count;
        cnt_inc    = {1'b0, frame_cnt} + 6'd1;
        right_hit  = ({1'b0, base_x} + STEP_X11 + FORM_W11) > X_MAX11;
        left_hit   = {1'b0, base_x} < (X_MIN11 + STEP_X11);
        invade_hit = ({1'b0, base_y} + STEP_Y11 + SPAN11) >= Y_LIMIT11;

        case (state)
            IDLE: begin
                frame_cnt_n = 5'd0;
                if (enable) begin
                    state_n = MARCH;
                end
            end
            MARCH: begin
                if (enable && (alive_count != 5'd0) && frame_edge) begin
                    if (cnt_inc >= {1'b0, period}) begin
                        frame_cnt_n = 5'd0;
                        if (dir_right) begin
                            if (right_hit) begin
                                state_n = DESCEND;
                            end else begin
                                base_x_n = base_x + STEP_X10;
                                pulse_n  = 1'b1;
                            end
                        end else begin
                            if (left_hit) begin
                                state_n = DESCEND;
                            end else begin
                                base_x_n = base_x - STEP_X10;
                                pulse_n  = 1'b1;
                            end
                        end
                    end else begin
                        frame_cnt_n = cnt_inc[4:0];
                    end
                end
            end
            DESCEND: begin
                base_y_n = base_y + STEP_Y10;
                dir_n    = ~dir_right;
                pulse_n  = 1'b1;
                if (invade_hit) begin
                    invaded_n = 1'b1;
                    state_n   = INVADED;
                end else begin
                    state_n = MARCH;
                end
            end
            INVADED: begin
                state_n = INVADED;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (restart) begin
            state_n     = IDLE;
            base_x_n    = X_START10;
            base_y_n    = Y_START10;
            dir_n       = 1'b1;
            pulse_n     = 1'b0;
            invaded_n   = 1'b0;
            frame_cnt_n = 5'd0;
        end
    end

    // Per-column and per-row positions fanned out from the base corner.
    always_comb begin
        col_x = '0;
        row_y = '0;
        for (int i = 0; i < COLS; i++) begin
            col_x[i*10 +: 10] = base_x + 10'(i * X_SPACING);
        end
        for (int k = 0; k < ROWS; k++) begin
            row_y[k*10 +: 10] = base_y + 10'(k * Y_SPACING);
        end
    end

endmodule

// File: tb/tb_invader_formation_ctrl.sv
// Directed testbench for invader_formation_ctrl with a scoreboard of
// expected formation moves checked on every step pulse.
module tb_invader_formation_ctrl;

    localparam int FORM_W    = (8 - 1) * 64 + 32;
    localparam int DROP_SPAN = (3 - 1) * 50 + 16;

    typedef struct {
        int x;
        int y;
        int dir;
        int inv;
    } sb_item_t;

    typedef enum int {M_IDLE, M_MARCH, M_INV} mstate_t;

    logic        clk;
    logic        reset;
    logic        vga_vs;
    logic        enable;
    logic        restart;
    logic [4:0]  alive_count;
    logic [79:0] col_x;
    logic [29:0] row_y;
    logic        dir_right;
    logic        step_pulse;
    logic        invaded;

    int checks = 0;
    int errors = 0;
    sb_item_t sb[$];

    int      m_x, m_y, m_dir, m_inv, m_cnt;
    mstate_t m_state;
    int      prev_pulse = 0;

    invader_formation_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .vga_vs      (vga_vs),
        .enable      (enable),
        .restart     (restart),
        .alive_count (alive_count),
        .col_x       (col_x),
        .row_y       (row_y),
        .dir_right   (dir_right),
        .step_pulse  (step_pulse),
        .invaded     (invaded)
    );

    // Free-running 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        m_x     = 32;
        m_y     = 40;
        m_dir   = 1;
        m_inv   = 0;
        m_cnt   = 0;
        m_state = M_IDLE;
        sb.delete();
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_col0"}, int'(col_x[9:0]), 32);
        checkOutput({tag, "_col7"}, int'(col_x[79:70]), 480);
        checkOutput({tag, "_row0"}, int'(row_y[9:0]), 40);
        checkOutput({tag, "_row2"}, int'(row_y[29:20]), 140);
        checkOutput({tag, "_dir"}, int'(dir_right), 1);
        checkOutput({tag, "_inv"}, int'(invaded), 0);
    endtask

    task automatic setEnable(input bit v);
        @(negedge clk);
        enable = v;
        repeat (2) @(negedge clk);
        if (v && m_state == M_IDLE) m_state = M_MARCH;
    endtask

    task automatic applyRestart();
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        modelReset();
        if (enable) begin
            repeat (2) @(negedge clk);
            m_state = M_MARCH;
        end
    endtask

    // One video frame: vsync low, model update, optional latency checks.
    task automatic applyStimulus(input bit chk_lat);
        int per;
        bit pushed;
        bit desc;
        pushed = 0;
        desc   = 0;
        @(negedge clk);
        vga_vs = 1'b0;
        if (m_state == M_MARCH && enable && alive_count != 0) begin
            per = (alive_count < 2) ? 2 : int'(alive_count);
            if (m_cnt + 1 >= per) begin
                m_cnt = 0;
                if (m_dir == 1) begin
                    if (m_x + 8 + FORM_W > 640) desc = 1;
                    else m_x = m_x + 8;
                end else begin
                    if (m_x < 0 + 8) desc = 1;
                    else m_x = m_x - 8;
                end
                if (desc) begin
                    if (m_y + 16 + DROP_SPAN >= 400) begin
                        m_inv   = 1;
                        m_state = M_INV;
                    end
                    m_y   = m_y + 16;
                    m_dir = 1 - m_dir;
                end
                sb.push_back('{x: m_x, y: m_y, dir: m_dir, inv: m_inv});
                pushed = 1;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        @(negedge clk);
        if (chk_lat) checkOutput("latency_1clk", int'(step_pulse), 0);
        @(negedge clk);
        if (chk_lat) checkOutput("latency_2clk", int'(step_pulse), int'(pushed && !desc));
        repeat (2) @(negedge clk);
        checkOutput("sb_drained", sb.size(), 0);
        vga_vs = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Scoreboard monitor: every step pulse must match the next expected move.
    always @(negedge clk) begin
        sb_item_t e;
        if (step_pulse === 1'b1) begin
            checkOutput("pulse_spacing", prev_pulse, 0);
            checkOutput("pulse_expected", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("sb_col0", int'(col_x[9:0]), e.x);
                checkOutput("sb_col7", int'(col_x[79:70]), e.x + 448);
                checkOutput("sb_row0", int'(row_y[9:0]), e.y);
                checkOutput("sb_row2", int'(row_y[29:20]), e.y + 100);
                checkOutput("sb_dir", int'(dir_right), e.dir);
                checkOutput("sb_inv", int'(invaded), e.inv);
            end
        end
        prev_pulse = (step_pulse === 1'b1) ? 1 : 0;
    end

    // Directed sequence covering reset, pacing, edges, invasion and restart.
    initial begin
        reset       = 1'b1;
        vga_vs      = 1'b1;
        enable      = 1'b0;
        restart     = 1'b0;
        alive_count = 5'd24;
        modelReset();
        #1;
        checkReset("por");
        checkOutput("por_pulse", int'(step_pulse), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Asynchronous reset in the middle of a march.
        setEnable(1);
        for (int f = 0; f < 3; f++) applyStimulus(0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkReset("async_rst");
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        m_state = M_MARCH;

        // First step only after the 24th frame.
        applyStimulus(1);
        for (int f = 1; f < 23; f++) applyStimulus(0);
        checkOutput("pre_step_col0", int'(col_x[9:0]), 32);
        applyStimulus(1);
        checkOutput("first_step_col0", int'(col_x[9:0]), 40);

        // March to the right edge, then descend and turn left.
        for (int f = 0; f < 15 * 24; f++) applyStimulus(0);
        checkOutput("edge_col0", int'(col_x[9:0]), 160);
        checkOutput("edge_col7", int'(col_x[79:70]), 608);
        checkOutput("edge_dir", int'(dir_right), 1);
        for (int f = 0; f < 24; f++) applyStimulus(0);
        checkOutput("descend_row0", int'(row_y[9:0]), 56);
        checkOutput("descend_dir", int'(dir_right), 0);
        checkOutput("descend_col0", int'(col_x[9:0]), 160);
        for (int f = 0; f < 24; f++) applyStimulus(0);
        checkOutput("left_step_col0", int'(col_x[9:0]), 152);

        // Period clamp and zero-alive freeze.
        alive_count = 5'd1;
        applyStimulus(0);
        checkOutput("clamp_half_col0", int'(col_x[9:0]), 152);
        applyStimulus(1);
        checkOutput("clamp_step_col0", int'(col_x[9:0]), 144);
        alive_count = 5'd0;
        for (int f = 0; f < 4; f++) applyStimulus(0);
        checkOutput("zero_alive_col0", int'(col_x[9:0]), 144);

        // Keep marching until the formation invades.
        alive_count = 5'd1;
        for (int f = 0; f < 1000 && m_inv == 0; f++) applyStimulus(0);
        checkOutput("invaded_model", m_inv, 1);
        checkOutput("invaded_flag", int'(invaded), 1);
        checkOutput("invaded_row0", int'(row_y[9:0]), 296);
        checkOutput("invaded_row2", int'(row_y[29:20]), 396);
        for (int f = 0; f < 4; f++) applyStimulus(0);
        checkOutput("frozen_row0", int'(row_y[9:0]), 296);
        checkOutput("frozen_col0", int'(col_x[9:0]), m_x);
        checkOutput("frozen_inv", int'(invaded), 1);
        applyRestart();
        checkReset("restart");

        // Restart coinciding with a step-triggering frame edge.
        alive_count = 5'd2;
        applyStimulus(0);
        @(negedge clk);
        vga_vs = 1'b0;
        @(negedge clk);
        restart = 1'b1;
        enable  = 1'b0;
        @(negedge clk);
        restart = 1'b0;
        modelReset();
        checkOutput("restart_win_pulse", int'(step_pulse), 0);
        repeat (2) @(negedge clk);
        checkOutput("restart_win_pulse_late", int'(step_pulse), 0);
        checkReset("restart_win");
        vga_vs = 1'b1;
        repeat (2) @(negedge clk);

        // Pause mid-count keeps the frame count.
        setEnable(1);
        alive_count = 5'd4;
        applyStimulus(0);
        applyStimulus(0);
        setEnable(0);
        for (int f = 0; f < 3; f++) applyStimulus(0);
        checkOutput("pause_col0", int'(col_x[9:0]), 32);
        setEnable(1);
        applyStimulus(0);
        checkOutput("resume_wait_col0", int'(col_x[9:0]), 32);
        applyStimulus(1);
        checkOutput("resume_step_col0", int'(col_x[9:0]), 40);

        repeat (4) @(negedge clk);
        checkOutput("sb_final_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/invader_formation_ctrl.md
Name: invader_formation_ctrl

Overview:
- Upstream motion stage for the enemy grid.
- Generates the per-column X and per-row Y positions that the SpaceInvaders top feeds to each Inimigo1 instance.
- Implements the classic march: the formation steps sideways once every N frames, drops one row and reverses at the screen edges, and freezes with an invasion flag when it reaches the player zone.
- Frame timing comes from the vga block's VGA_VS.

Parameters:
COLS, 8, formation columns
ROWS, 3, formation rows
X_START, 32, reset X of column 0 (pixels)
X_SPACING, 64, column pitch
Y_START, 40, reset Y of row 0
Y_SPACING, 50, row pitch
SPRITE_W, 32, enemy sprite width
SPRITE_H, 16, enemy sprite height
X_MIN, 0, left screen bound
X_MAX, 640, right screen bound (exclusive)
STEP_X, 8, horizontal step (pixels)
STEP_Y, 16, vertical drop (pixels)
Y_LIMIT, 400, invasion line
MIN_PERIOD, 2, minimum frames per step

Ports:
clk  input  1  system clock (same clk as the top)
reset  input  1  asynchronous, active-high reset
vga_vs  input  1  VGA_VS from vga block, active-low vertical sync
enable  input  1  game running; 0 pauses motion
restart  input  1  synchronous one-cycle reinitialisation pulse
alive_count  input  5  number of living enemies (0..24)
col_x  output  COLS*10  packed column X positions; col i at [10i+9:10i]
row_y  output  ROWS*10  packed row Y positions; row k at [10k+9:10k]
dir_right  output  1  current march direction
step_pulse  output  1  one-cycle pulse on every applied move
invaded  output  1  formation reached Y_LIMIT

Behaviour:
- Reset is asynchronous, active-high; clock and reset are the single clk and reset.
- Reset values:
  - base_x=X_START, base_y=Y_START, dir_right=1.
  - step_pulse=0, invaded=0, frame_cnt=0.
  - State IDLE; vsync sample registers = 1.
- Outputs are combinational from registered base:
  - col_x[i] = base_x + i*X_SPACING.
  - row_y[k] = base_y + k*Y_SPACING.
- Frame edge: vga_vs is registered twice. frame_edge is asserted for one clk when the second stage is 1 and the first stage is 0 (falling edge). Latency is 2 cycles.
- Step period: period = max(alive_count, MIN_PERIOD).
- Derived constant: W = (COLS-1)*X_SPACING + SPRITE_W. All bound arithmetic is done in 11 bits and cannot wrap.
- FSM:
  - IDLE: hold positions, frame_cnt=0. Go to MARCH when enable=1.
  - MARCH:
    - Nothing happens if enable=0 or alive_count=0 (frame_cnt held).
    - On frame_edge, frame_cnt increments. When frame_cnt+1 >= period, frame_cnt clears and a step is evaluated.
    - If period shrinks below the current frame_cnt, the step fires on the next frame_edge.
  - Step evaluation, in the same cycle:
    - Right: if base_x + STEP_X + W > X_MAX, go to DESCEND. Otherwise base_x += STEP_X and step_pulse=1.
    - Left: if base_x < X_MIN + STEP_X, go to DESCEND. Otherwise base_x -= STEP_X and step_pulse=1.
  - DESCEND (exactly 1 cycle): base_y += STEP_Y, dir_right toggles, step_pulse=1, no X motion.
    - If base_y + STEP_Y + (ROWS-1)*Y_SPACING + SPRITE_H >= Y_LIMIT, set invaded=1 and go to INVADED.
    - Otherwise return to MARCH.
  - INVADED: all positions frozen and invaded held at 1 until reset or restart.
- restart: has the same effect as reset, synchronously, in every state. It has priority over a frame_edge or step in the same cycle.
- enable deasserting in MARCH pauses motion with frame_cnt held; the FSM does not return to IDLE.
- step_pulse is never high for two consecutive cycles.

Test Plan:
1. Reset asserted mid-MARCH, asynchronously between clk edges -> outputs return immediately to col_x[0]=32, col_x[7]=480, row_y[0]=40, row_y[2]=140, dir_right=1, invaded=0.
2. enable=1, alive_count=24, 24 vga_vs falling edges -> exactly one step_pulse, 2 clk after the 24th edge; base_x=40. No pulse after edges 1..23.
3. alive_count=24, 16 steps -> base_x=160, right edge 640. Step 17 -> DESCEND: base_y=56, dir_right=0, base_x=160. Following steps decrement X by 8.
4. alive_count=1 -> period clamps to MIN_PERIOD=2: a step every 2 frames. alive_count=0 -> no steps.
5. Force repeated edge hits until base_y reaches 296 -> invaded=1 on that DESCEND. Further frames -> positions unchanged. restart pulse -> all reset values restored, state IDLE.
6. restart and frame_edge in the same cycle, and enable toggled low mid-count -> restart wins. Pause holds frame_cnt; the step lands after the remaining frames once enable returns.
